// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO using every one of its 2**ADDR_WIDTH entries.
// Provides an occupancy count, threshold flags, error pulses, a flush input and an optional FWFT read port.
module sync_fifo_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  Wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rd_acc;
  logic                  wr_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

  // The extra MSB on each pointer tells a full ring apart from an empty one.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_addr == rd_addr) && (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

  assign almost_full  = (count_reg >= AF_LVL);
  assign almost_empty = (count_reg <= AE_LVL);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A read in the same cycle frees a slot, so a full FIFO can still take a write.
  assign rd_acc = Read_enable & ~empty;
  assign wr_acc = Wr_enable & (~full | rd_acc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overflow_reg  <= Wr_enable & ~wr_acc;
      underflow_reg <= Read_enable & ~rd_acc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem[gi] <= '0;
        end else if (wr_acc && !clear && (wr_addr == ADDR_WIDTH'(gi))) begin
          mem[gi] <= data_in;
        end
      end
    end

    if (FWFT) begin : g_fwft
      assign data_out = mem[rd_addr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dout_reg <= '0;
        end else if (rd_acc && !clear) begin
          dout_reg <= mem[rd_addr];
        end
      end
      assign data_out = dout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a standard-mode instance checked against a queue model,
// plus an FWFT instance for fall-through and asynchronous reset behaviour.
module tb_sync_fifo_v2;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       s_rst, s_clr, s_we, s_re;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [5:0] s_count;

  // FWFT instance
  logic       f_rst, f_clr, f_we, f_re;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [5:0] f_count;

  sync_fifo_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1'b0)) u_std (
    .clk(clk), .reset(s_rst), .clear(s_clr), .Wr_enable(s_we), .data_in(s_din),
    .Read_enable(s_re), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(f_rst), .clear(f_clr), .Wr_enable(f_we), .data_in(f_din),
    .Read_enable(f_re), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  int total = 0;
  int bad = 0;

  // behavioural model of the standard instance
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_unf;

  function automatic logic [3:0] exp_flags();
    int sz = q.size();
    return {sz == DEPTH, sz == 0, sz >= DEPTH - 2, sz <= 2};
  endfunction

  // Drive one cycle on the standard instance, update the model, sample after the edge.
  task automatic drive(input bit we, input bit re, input bit clr, input logic [7:0] din);
    bit rd, wr;
    s_we = we; s_re = re; s_clr = clr; s_din = din;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd = re && (q.size() > 0);
      wr = we && ((q.size() < DEPTH) || rd);
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(din);
      m_ovf = we && !wr;
      m_unf = re && !rd;
    end
    @(posedge clk); #1;
    s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0;
  endtask

  task automatic test_reset();
    s_rst = 1'b0; s_clr = 0; s_we = 0; s_re = 0; s_din = 0;
    f_rst = 1'b0; f_clr = 0; f_we = 0; f_re = 0; f_din = 0;
    q.delete(); m_dout = 8'h00; m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);
    #1; s_rst = 1'b1; f_rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin
      bad++; $display("FAIL reset_flags: got e/f/ae/af=%b want 1010", {s_empty, s_full, s_ae, s_af});
    end
    total++;
    if (s_count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", s_count); end
    total++;
    if (s_dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", s_dout); end
    total++;
    if ({s_ovf, s_unf} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {s_ovf, s_unf}); end
    $display("reset: empty=%b full=%b count=%0d", s_empty, s_full, s_count);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 8'(i));
      total++;
      if (int'(s_count) !== i + 1) begin bad++; $display("FAIL fill_count: got %0d want %0d", s_count, i + 1); end
      total++;
      if ({s_full, s_af} !== {1'(i + 1 == DEPTH), 1'(i + 1 >= DEPTH - 2)}) begin
        bad++; $display("FAIL fill_flags: count=%0d got full/af=%b%b", i + 1, s_full, s_af);
      end
      $display("fill: wrote %h count=%0d full=%b af=%b", 8'(i), s_count, s_full, s_af);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 8'h00);
      total++;
      if (s_dout !== 8'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", s_dout, 8'(i)); end
      $display("drain: read %h count=%0d", s_dout, s_count);
    end
    total++;
    if (s_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", s_empty); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 8'($urandom));
    drive(1, 0, 0, 8'hEE);
    total++;
    if (s_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", s_ovf); end
    total++;
    if (s_count !== 6'd32) begin bad++; $display("FAIL ovf_count: got %0d want 32", s_count); end
    $display("overflow: ovf=%b count=%0d", s_ovf, s_count);
    drive(0, 0, 0, 8'h00);
    total++;
    if (s_ovf !== 1'b0) begin bad++; $display("FAIL ovf_onecycle: got %b want 0", s_ovf); end
    while (q.size() > 0) begin
      drive(0, 1, 0, 8'h00);
      total++;
      if (s_dout !== m_dout) begin bad++; $display("FAIL ovf_contents: got %h want %h", s_dout, m_dout); end
    end
    drive(0, 1, 0, 8'h00);
    total++;
    if (s_unf !== 1'b1) begin bad++; $display("FAIL unf_pulse: got %b want 1", s_unf); end
    total++;
    if (s_dout !== m_dout) begin bad++; $display("FAIL unf_dout: got %h want %h", s_dout, m_dout); end
    $display("underflow: unf=%b dout=%h", s_unf, s_dout);
    drive(0, 0, 0, 8'h00);
    total++;
    if (s_unf !== 1'b0) begin bad++; $display("FAIL unf_onecycle: got %b want 0", s_unf); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 8'($urandom_range(0, 8'h7F)));
    drive(1, 1, 0, 8'hAA);
    total++;
    if (s_count !== 6'd32 || s_ovf !== 1'b0) begin
      bad++; $display("FAIL simul_full: got count=%0d ovf=%b want 32/0", s_count, s_ovf);
    end
    total++;
    if (s_dout !== m_dout) begin bad++; $display("FAIL simul_full_head: got %h want %h", s_dout, m_dout); end
    $display("simul full: count=%0d dout=%h", s_count, s_dout);
    while (q.size() > 0) begin
      drive(0, 1, 0, 8'h00);
      total++;
      if (s_dout !== m_dout) begin bad++; $display("FAIL simul_order: got %h want %h", s_dout, m_dout); end
    end
    total++;
    if (s_dout !== 8'hAA) begin bad++; $display("FAIL simul_last: got %h want aa", s_dout); end
    drive(1, 1, 0, 8'h3C);
    total++;
    if (s_count !== 6'd1 || s_unf !== 1'b1) begin
      bad++; $display("FAIL simul_empty: got count=%0d unf=%b want 1/1", s_count, s_unf);
    end
    total++;
    if (s_dout !== 8'hAA) begin bad++; $display("FAIL simul_empty_dout: got %h want aa", s_dout); end
    $display("simul empty: count=%0d unf=%b dout=%h", s_count, s_unf, s_dout);
    drive(0, 1, 0, 8'h00);
    total++;
    if (s_dout !== 8'h3C) begin bad++; $display("FAIL simul_empty_word: got %h want 3c", s_dout); end
  endtask

  task automatic test_wrap_random();
    for (int i = 0; i < 100; i++) begin
      bit we = ($urandom_range(0, 99) < (i < 50 ? 65 : 40));
      bit re = ($urandom_range(0, 99) < (i < 50 ? 40 : 65));
      drive(we, re, 0, 8'($urandom));
      total++;
      if (int'(s_count) !== q.size()) begin bad++; $display("FAIL rand_count: cyc %0d got %0d want %0d", i, s_count, q.size()); end
      total++;
      if (s_dout !== m_dout) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", i, s_dout, m_dout); end
      total++;
      if ({s_full, s_empty, s_af, s_ae} !== exp_flags()) begin
        bad++; $display("FAIL rand_flags: cyc %0d got %b want %b", i, {s_full, s_empty, s_af, s_ae}, exp_flags());
      end
      total++;
      if ({s_ovf, s_unf} !== {m_ovf, m_unf}) begin
        bad++; $display("FAIL rand_err: cyc %0d got %b want %b", i, {s_ovf, s_unf}, {m_ovf, m_unf});
      end
      $display("rand %0d: we=%b re=%b count=%0d dout=%h", i, we, re, s_count, s_dout);
    end
    while (q.size() < DEPTH) drive(1, 0, 0, 8'($urandom));
    drive(1, 0, 1, 8'h77);
    total++;
    if (s_count !== 6'd0 || s_empty !== 1'b1) begin
      bad++; $display("FAIL clear_state: got count=%0d empty=%b want 0/1", s_count, s_empty);
    end
    total++;
    if (s_ovf !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %b want 0", s_ovf); end
    total++;
    if (s_dout !== m_dout) begin bad++; $display("FAIL clear_dout: got %h want %h", s_dout, m_dout); end
    $display("clear: count=%0d empty=%b ovf=%b", s_count, s_empty, s_ovf);
  endtask

  task automatic test_fwft();
    logic [7:0] fq[$];
    f_we = 1; f_din = 8'h5A;
    @(posedge clk); #1; f_we = 0;
    total++;
    if (f_dout !== 8'h5A || f_empty !== 1'b0) begin
      bad++; $display("FAIL fwft_show: got dout=%h empty=%b want 5a/0", f_dout, f_empty);
    end
    $display("fwft write: dout=%h empty=%b", f_dout, f_empty);
    f_re = 1;
    @(posedge clk); #1; f_re = 0;
    total++;
    if (f_empty !== 1'b1 || f_count !== 6'd0) begin
      bad++; $display("FAIL fwft_pop: got empty=%b count=%0d want 1/0", f_empty, f_count);
    end
    for (int i = 0; i < 4; i++) begin
      f_we = 1; f_din = 8'($urandom); fq.push_back(f_din);
      @(posedge clk); #1; f_we = 0;
      total++;
      if (f_dout !== fq[0]) begin bad++; $display("FAIL fwft_head: got %h want %h", f_dout, fq[0]); end
    end
    f_re = 1;
    @(posedge clk); #1; f_re = 0;
    void'(fq.pop_front());
    total++;
    if (f_dout !== fq[0]) begin bad++; $display("FAIL fwft_next: got %h want %h", f_dout, fq[0]); end
    $display("fwft pop: dout=%h count=%0d", f_dout, f_count);
    f_we = 1; f_din = 8'hC3;
    @(posedge clk); #1;
    f_rst = 1'b0;
    #1;
    total++;
    if (f_empty !== 1'b1 || f_count !== 6'd0) begin
      bad++; $display("FAIL fwft_async_rst: got empty=%b count=%0d want 1/0", f_empty, f_count);
    end
    $display("fwft reset: empty=%b count=%0d", f_empty, f_count);
    @(posedge clk); #1;
    f_we = 0; f_rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (f_empty !== 1'b1 || f_ovf !== 1'b0) begin
      bad++; $display("FAIL fwft_post_rst: got empty=%b ovf=%b want 1/0", f_empty, f_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_wrap_random();
    test_fwft();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
